// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: shared widths, opcodes, timing-state encodings and IR field positions for proc_ctrl.
package proc_ctrl_pkg;
    localparam int REG_IDX_W = 3;
    localparam int SEL_W     = 4;
    localparam int OP_W      = 3;
    localparam int IR_W      = OP_W + 2 * REG_IDX_W;
    localparam int III_LSB   = 2 * REG_IDX_W;
    localparam int XXX_LSB   = REG_IDX_W;
    localparam int YYY_LSB   = 0;
    localparam logic [OP_W-1:0] OP_MV  = 3'b000;
    localparam logic [OP_W-1:0] OP_MVI = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b011;
    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;
    function automatic logic is_alu(input logic [OP_W-1:0] op);
        return op == OP_ADD || op == OP_SUB;
    endfunction
endpackage

// File: rtl/proc_ctrl_decode.sv
// proc_ctrl_decode: combinational map from timing state and latched IR to every datapath control.
module proc_ctrl_decode
    import proc_ctrl_pkg::*;
(
    input  state_t            i_state,
    input  logic              i_run,
    input  logic [IR_W-1:0]   i_ir,
    output logic              o_ir_in,
    output logic [SEL_W-1:0]  o_rin_bin,
    output logic              o_rin_en,
    output logic [SEL_W-1:0]  o_rout_bin,
    output logic              o_rout_en,
    output logic              o_din_out,
    output logic              o_a_in,
    output logic              o_g_in,
    output logic              o_g_out,
    output logic              o_addsub,
    output logic              o_done
);
    logic [OP_W-1:0]      w_op;
    logic [REG_IDX_W-1:0] w_x, w_y, w_rout_idx;
    logic                 w_alu, w_mv, w_mvi, w_t1, w_t2, w_t3;

    assign w_op  = i_ir[III_LSB +: OP_W];
    assign w_x   = i_ir[XXX_LSB +: REG_IDX_W];
    assign w_y   = i_ir[YYY_LSB +: REG_IDX_W];
    assign w_alu = is_alu(w_op);
    assign w_mv  = w_op == OP_MV;
    assign w_mvi = w_op == OP_MVI;
    assign w_t1  = i_state == T1;
    assign w_t2  = i_state == T2;
    assign w_t3  = i_state == T3;

    // ALU ops put X on the bus first (into A), then Y (into G)
    assign w_rout_idx = (w_t1 && w_alu) ? w_x : w_y;

    assign o_ir_in    = i_state == T0 && i_run;
    assign o_rout_en  = (w_t1 && (w_mv || w_alu)) || (w_t2 && w_alu);
    assign o_rin_en   = (w_t1 && (w_mv || w_mvi)) || (w_t3 && w_alu);
    assign o_rout_bin = o_rout_en ? SEL_W'(w_rout_idx) : '0;
    assign o_rin_bin  = o_rin_en ? SEL_W'(w_x) : '0;
    assign o_din_out  = w_t1 && w_mvi;
    assign o_a_in     = w_t1 && w_alu;
    assign o_g_in     = w_t2 && w_alu;
    assign o_addsub   = w_t2 && w_op == OP_SUB;
    assign o_g_out    = w_t3 && w_alu;
    assign o_done     = (w_t1 && !w_alu) || (w_t3 && w_alu);
endmodule

// File: rtl/proc_ctrl.sv
// proc_ctrl: multi-cycle CPU control unit (state register, IR latch, decode).
// Define PROC_CTRL_PERF_EN to add the 16-bit retired-instruction counter instr_count.
module proc_ctrl
    import proc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              run,
    input  logic [IR_W-1:0]   instr,
`ifdef PROC_CTRL_PERF_EN
    output logic [15:0]       instr_count,
`endif
    output logic              ir_in,
    output logic [SEL_W-1:0]  rin_bin,
    output logic              rin_en,
    output logic [SEL_W-1:0]  rout_bin,
    output logic              rout_en,
    output logic              din_out,
    output logic              a_in,
    output logic              g_in,
    output logic              g_out,
    output logic              addsub,
    output logic              done
);
    state_t            r_state, w_next;
    logic [IR_W-1:0]   r_ir;
    logic              w_alu, w_run;

    assign w_alu = is_alu(r_ir[III_LSB +: OP_W]);
    // run is masked so ir_in stays low while reset is held
    assign w_run = run && resetn;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == T0 && run) r_ir <= instr;
        end
    end

    always_comb begin
        w_next = (r_state == T0) ? (run ? T1 : T0) :
                 (r_state == T1 && w_alu) ? T2 :
                 (r_state == T2 && w_alu) ? T3 : T0;
    end

    proc_ctrl_decode u_decode (
        .i_state    (r_state),
        .i_run      (w_run),
        .i_ir       (r_ir),
        .o_ir_in    (ir_in),
        .o_rin_bin  (rin_bin),
        .o_rin_en   (rin_en),
        .o_rout_bin (rout_bin),
        .o_rout_en  (rout_en),
        .o_din_out  (din_out),
        .o_a_in     (a_in),
        .o_g_in     (g_in),
        .o_g_out    (g_out),
        .o_addsub   (addsub),
        .o_done     (done)
    );

`ifdef PROC_CTRL_PERF_EN
    logic [15:0] r_cnt;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_cnt <= '0;
        else if (done) r_cnt <= r_cnt + 16'd1;
    end
    assign instr_count = r_cnt;
`endif
endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: scoreboard bench for proc_ctrl; expected per-cycle control vectors are
// queued when an instruction is issued and popped each cycle as the DUT drives its outputs.
module tb_proc_ctrl;
    logic        clk = 0, resetn = 0, run = 0;
    logic [8:0]  instr = '0;
    logic        ir_in, rin_en, rout_en, din_out, a_in, g_in, g_out, addsub, done;
    logic [3:0]  rin_bin, rout_bin;
    logic [16:0] w_outv;
    logic [16:0] sb[$];
    int          n_chk = 0, n_pass = 0;
`ifdef PROC_CTRL_PERF_EN
    logic [15:0] instr_count;
`endif

    always #5 clk = ~clk;

    proc_ctrl dut (
        .clk      (clk),
        .resetn   (resetn),
        .run      (run),
        .instr    (instr),
`ifdef PROC_CTRL_PERF_EN
        .instr_count (instr_count),
`endif
        .ir_in    (ir_in),
        .rin_bin  (rin_bin),
        .rin_en   (rin_en),
        .rout_bin (rout_bin),
        .rout_en  (rout_en),
        .din_out  (din_out),
        .a_in     (a_in),
        .g_in     (g_in),
        .g_out    (g_out),
        .addsub   (addsub),
        .done     (done)
    );

    assign w_outv = {ir_in, rin_en, rin_bin, rout_en, rout_bin, din_out, a_in, g_in, g_out, addsub, done};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [16:0] mk(input logic ii, input logic re, input logic [2:0] ri,
                                       input logic oe, input logic [2:0] oi, input logic di,
                                       input logic a, input logic gi, input logic go,
                                       input logic as, input logic dn);
        return {ii, re, re ? {1'b0, ri} : 4'd0, oe, oe ? {1'b0, oi} : 4'd0, di, a, gi, go, as, dn};
    endfunction

    function automatic int push_instr(input logic [8:0] ins);
        logic [2:0] op, x, y;
        op = ins[8:6]; x = ins[5:3]; y = ins[2:0];
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (op == 3'b000) sb.push_back(mk(0, 1, x, 1, y, 0, 0, 0, 0, 0, 1));
        else if (op == 3'b001) sb.push_back(mk(0, 1, x, 0, 0, 1, 0, 0, 0, 0, 1));
        else if (op == 3'b010 || op == 3'b011) begin
            sb.push_back(mk(0, 0, 0, 1, x, 0, 1, 0, 0, 0, 0));
            sb.push_back(mk(0, 0, 0, 1, y, 0, 0, 1, 0, op[0], 0));
            sb.push_back(mk(0, 1, x, 0, 0, 0, 0, 0, 1, 0, 1));
            return 4;
        end else sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        return 2;
    endfunction

    task automatic cyc(input string tag, input logic r, input logic [8:0] ins);
        logic [16:0] e;
        run = r; instr = ins;
        @(negedge clk);
        if (sb.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
        else begin
            e = sb.pop_front();
            chk(tag, 32'(w_outv), 32'(e));
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input string tag, input logic r);
        sb.push_back('0);
        cyc(tag, r, 9'($urandom));
    endtask

    // run_mask bit i is the run level driven in cycle i of the instruction
    task automatic issue(input string tag, input logic [8:0] ins, input logic [3:0] run_mask);
        int n;
        n = push_instr(ins);
        for (int i = 0; i < n; i++)
            cyc($sformatf("%s_c%0d", tag, i), run_mask[i], i == 0 ? ins : 9'($urandom));
    endtask

    initial begin
        logic [8:0] r_ins;
        #1;
        idle("reset_run_ignored0", 1);
        idle("reset_run_ignored1", 1);
        resetn = 1;
        idle("idle_after_reset", 0);
        issue("mvi_r3", 9'b001_011_000, 4'b0001);
        issue("mv_r5_r2", 9'b000_101_010, 4'b0001);
        issue("sub_r1_r7", 9'b011_001_111, 4'b0001);
        idle("idle_after_sub", 0);
        issue("nop_110", 9'b110_000_000, 4'b1111);
        issue("add_b2b_drop", 9'b010_100_110, 4'b0011);
        idle("idle_after_add", 0);
        issue("add_xx", 9'b010_010_010, 4'b0001);
        issue("sub_xx", 9'b011_110_110, 4'b0001);
        for (int op = 4; op < 8; op++)
            issue($sformatf("nop%0d", op), {3'(op), 6'($urandom)}, 4'b1111);
        for (int k = 0; k < 24; k++) begin
            r_ins = 9'($urandom);
            r_ins[8] = ($urandom_range(0, 3) == 0);
            issue($sformatf("rand%0d", k), r_ins, 4'($urandom) | 4'b0001);
        end
        idle("idle_pre_rst", 0);
        // reset asserted asynchronously while an add sits in T2
        void'(push_instr(9'b010_011_101));
        cyc("rst_add_t0", 1, 9'b010_011_101);
        cyc("rst_add_t1", 0, 9'h0);
        run = 1;
        @(negedge clk);
        chk("rst_add_t2", 32'(w_outv), 32'(sb.pop_front()));
        #2 resetn = 0;
        #1 chk("rst_async_zero", 32'(w_outv), 0);
        sb.delete();
        @(posedge clk); #1;
        idle("rst_held_run", 1);
        resetn = 1;
        issue("mvi_after_rst", 9'b001_111_000, 4'b0001);
        issue("mv_after_rst", 9'b000_000_111, 4'b0001);
        chk("sb_drained", sb.size(), 0);
`ifdef PROC_CTRL_PERF_EN
        resetn = 0; #1; resetn = 1;
        @(posedge clk); #1;
        run = 1; instr = 9'b111_000_000;
        repeat (2 * 65537) @(posedge clk);
        #1 run = 0;
        @(negedge clk);
        chk("perf_wrap", instr_count, 16'd1);
        resetn = 0; #1;
        chk("perf_reset", instr_count, 16'd0);
        resetn = 1;
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
